// File: rtl/audio_mem_streamer.sv
// audio_mem_streamer: Avalon-MM master for the on-chip sample memory (s1).
// Record mode writes ADC samples to memory. Playback mode reads them back
// and passes them to the DAC transmit path with a valid/ready handshake.
// Optional feature macro: AUDIO_MEM_LOOP_PLAYBACK_EN. When it is defined,
// playback wraps to address 0 after the last sample and runs until stop.
module audio_mem_streamer #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 262144
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                rec_start,
  input  logic                play_start,
  input  logic                stop,
  input  logic [DATA_W-1:0]   adc_sample,
  input  logic                adc_valid,
  output logic [DATA_W-1:0]   dac_sample,
  output logic                dac_valid,
  input  logic                dac_ready,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                busy,
  output logic [ADDR_W:0]     rec_count,
  output logic                full
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    REC,
    PLAY_RD,
    PLAY_WAIT,
    PLAY_HOLD
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W:0]     ptr_reg, ptr_next;
  logic [ADDR_W:0]     rec_count_reg, rec_count_next;
  logic                full_reg, full_next;
  logic [DATA_W-1:0]   dac_sample_reg, dac_sample_next;
  logic                dac_valid_reg, dac_valid_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                cs_reg, cs_next;
  logic                wr_reg, wr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [BE_W-1:0]     be_reg;
  logic                clken_reg;
  logic                last_sample;

  // Playback has reached the final recorded sample.
  assign last_sample = (ptr_reg == rec_count_reg - 1'b1);

  // State and every registered output; the bus strobes are precomputed
  // so they appear in the same cycle as the state that owns them.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      rec_count_reg  <= '0;
      full_reg       <= 1'b0;
      dac_sample_reg <= '0;
      dac_valid_reg  <= 1'b0;
      addr_reg       <= '0;
      cs_reg         <= 1'b0;
      wr_reg         <= 1'b0;
      wdata_reg      <= '0;
      be_reg         <= '0;
      clken_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      rec_count_reg  <= rec_count_next;
      full_reg       <= full_next;
      dac_sample_reg <= dac_sample_next;
      dac_valid_reg  <= dac_valid_next;
      addr_reg       <= addr_next;
      cs_reg         <= cs_next;
      wr_reg         <= wr_next;
      wdata_reg      <= wdata_next;
      be_reg         <= cs_next ? {BE_W{1'b1}} : {BE_W{1'b0}};
      clken_reg      <= 1'b1;
    end
  end

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    rec_count_next  = rec_count_reg;
    full_next       = full_reg;
    dac_sample_next = dac_sample_reg;
    dac_valid_next  = dac_valid_reg;
    addr_next       = addr_reg;
    cs_next         = 1'b0;
    wr_next         = 1'b0;
    wdata_next      = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (rec_start) begin
          state_next     = REC;
          ptr_next       = '0;
          rec_count_next = '0;
          full_next      = 1'b0;
        end else if (play_start && (rec_count_reg != '0)) begin
          state_next = PLAY_RD;
          ptr_next   = '0;
          cs_next    = 1'b1;
          addr_next  = '0;
        end
      end
      REC: begin
        // A sample arriving together with stop is still written and counted.
        if (adc_valid) begin
          cs_next        = 1'b1;
          wr_next        = 1'b1;
          addr_next      = ptr_reg[ADDR_W-1:0];
          wdata_next     = adc_sample;
          ptr_next       = ptr_reg + 1'b1;
          rec_count_next = rec_count_reg + 1'b1;
          if (rec_count_reg + 1'b1 == DEPTH_C) begin
            full_next  = 1'b1;
            state_next = IDLE;
          end
        end
        if (stop) begin
          state_next = IDLE;
        end
      end
      PLAY_RD: begin
        state_next = stop ? IDLE : PLAY_WAIT;
      end
      PLAY_WAIT: begin
        // Read data is valid this cycle; stop throws it away.
        if (stop) begin
          state_next = IDLE;
        end else begin
          dac_sample_next = mem_readdata;
          dac_valid_next  = 1'b1;
          state_next      = PLAY_HOLD;
        end
      end
      PLAY_HOLD: begin
        if (stop) begin
          dac_valid_next = 1'b0;
          state_next     = IDLE;
        end else if (dac_valid_reg && dac_ready) begin
          dac_valid_next = 1'b0;
          if (last_sample) begin
`ifdef AUDIO_MEM_LOOP_PLAYBACK_EN
            ptr_next   = '0;
            cs_next    = 1'b1;
            addr_next  = '0;
            state_next = PLAY_RD;
`else
            ptr_next   = ptr_reg + 1'b1;
            state_next = IDLE;
`endif
          end else begin
            ptr_next   = ptr_reg + 1'b1;
            cs_next    = 1'b1;
            addr_next  = ptr_reg[ADDR_W-1:0] + 1'b1;
            state_next = PLAY_RD;
          end
        end
      end
      default: begin
        state_next     = IDLE;
        dac_valid_next = 1'b0;
      end
    endcase
  end

  assign dac_sample     = dac_sample_reg;
  assign dac_valid      = dac_valid_reg;
  assign mem_address    = addr_reg;
  assign mem_chipselect = cs_reg;
  assign mem_write      = wr_reg;
  assign mem_clken      = clken_reg;
  assign mem_byteenable = be_reg;
  assign mem_writedata  = wdata_reg;
  assign busy           = (state_reg != IDLE);
  assign rec_count      = rec_count_reg;
  assign full           = full_reg;

endmodule

// File: tb/tb_audio_mem_streamer.sv
// Testbench for audio_mem_streamer, built with DEPTH = 8 so the full case
// is reachable. A small memory model with read latency 1 stands in for s1.
module tb_audio_mem_streamer;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;

  logic              clk_clk;
  logic              reset_reset_n;
  logic              rec_start, play_start, stop;
  logic [DATA_W-1:0] adc_sample;
  logic              adc_valid;
  logic [DATA_W-1:0] dac_sample;
  logic              dac_valid;
  logic              dac_ready;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [1:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              busy;
  logic [ADDR_W:0]   rec_count;
  logic              full;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem_model [0:15];
  logic [15:0] play_exp  [0:3];

  audio_mem_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .rec_start      (rec_start),
    .play_start     (play_start),
    .stop           (stop),
    .adc_sample     (adc_sample),
    .adc_valid      (adc_valid),
    .dac_sample     (dac_sample),
    .dac_valid      (dac_valid),
    .dac_ready      (dac_ready),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_clken      (mem_clken),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .busy           (busy),
    .rec_count      (rec_count),
    .full           (full)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  // Memory model: synchronous write, registered read (latency 1).
  always @(posedge clk_clk) begin
    if (mem_chipselect && mem_write) mem_model[mem_address[3:0]] <= mem_writedata;
    if (mem_chipselect && !mem_write) mem_readdata <= mem_model[mem_address[3:0]];
  end

  typedef struct {
    logic        rs, ps, sp, av;
    logic [15:0] smp;
    logic        cs;
    logic [17:0] addr;
    logic        bz;
    logic [18:0] cnt;
    logic        fl;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mv(input logic rs, input logic ps, input logic sp, input logic av,
                              input logic [15:0] smp, input logic cs, input logic [17:0] addr,
                              input logic bz, input logic [18:0] cnt, input logic fl);
    vec_t v;
    v.rs = rs; v.ps = ps; v.sp = sp; v.av = av; v.smp = smp;
    v.cs = cs; v.addr = addr; v.bz = bz; v.cnt = cnt; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cs"}, mem_chipselect, 0);
    chk({tag, "_we"}, mem_write, 0);
    chk({tag, "_addr"}, mem_address, 0);
    chk({tag, "_wd"}, mem_writedata, 0);
    chk({tag, "_be"}, mem_byteenable, 0);
    chk({tag, "_clken"}, mem_clken, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cnt"}, rec_count, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_dv"}, dac_valid, 0);
    chk({tag, "_dsmp"}, dac_sample, 0);
  endtask

  // Play back n samples from play_exp; sample stall_idx is held off with
  // dac_ready low for stall_len cycles.
  task automatic play_seq(input int n, input int stall_idx, input int stall_len);
    int stall;
    play_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      play_start = 1'b0;
      dac_ready  = 1'b0;
      chk("rd_cs", mem_chipselect, 1);
      chk("rd_we", mem_write, 0);
      chk("rd_addr", mem_address, i);
      chk("rd_be", mem_byteenable, 2'b11);
      chk("rd_dv", dac_valid, 0);
      chk("rd_busy", busy, 1);
      tick();
      chk("wait_cs", mem_chipselect, 0);
      chk("wait_dv", dac_valid, 0);
      stall = (i == stall_idx) ? stall_len : 0;
      for (int s = 0; s <= stall; s++) begin
        tick();
        chk("hold_dv", dac_valid, 1);
        chk("hold_smp", dac_sample, play_exp[i]);
        chk("hold_cs", mem_chipselect, 0);
        dac_ready = (s == stall);
      end
      $display("play sample %0d addr=%0d data=%h stall=%0d", i, i, play_exp[i], stall);
    end
    tick();
    dac_ready = 1'b0;
    chk("end_dv", dac_valid, 0);
`ifdef AUDIO_MEM_LOOP_PLAYBACK_EN
    chk("end_wrap_cs", mem_chipselect, 1);
    chk("end_wrap_addr", mem_address, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("end_busy", busy, 0);
`else
    chk("end_busy", busy, 0);
    chk("end_cs", mem_chipselect, 0);
`endif
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 16; i++) mem_model[i] = 16'h0;
    mem_readdata  = 16'h0;
    reset_reset_n = 1'b0;
    rec_start = 0; play_start = 0; stop = 0;
    adc_sample = 0; adc_valid = 0; dac_ready = 0;

    // Recording table: inputs in cycle N, expected outputs in cycle N+1.
    vq.push_back(mv(1,0,0,0,16'h0000, 0, 0, 1, 0, 0));
    vq.push_back(mv(0,0,0,1,16'h1111, 1, 0, 1, 1, 0));
    vq.push_back(mv(0,0,0,1,16'h2222, 1, 1, 1, 2, 0));
    vq.push_back(mv(1,0,0,0,16'h0000, 0, 0, 1, 2, 0));
    vq.push_back(mv(0,1,0,0,16'h0000, 0, 0, 1, 2, 0));
    vq.push_back(mv(0,0,0,1,16'h3333, 1, 2, 1, 3, 0));
    vq.push_back(mv(0,0,0,1,16'h4444, 1, 3, 1, 4, 0));
    vq.push_back(mv(0,0,1,0,16'h0000, 0, 0, 0, 4, 0));
    vq.push_back(mv(0,0,1,0,16'h0000, 0, 0, 0, 4, 0));

    // Reset state.
    tick(); tick();
    chk_all_zero("rst");
    reset_reset_n = 1'b1;
    tick();
    chk("rst_clken", mem_clken, 1);
    chk("rst_idle", busy, 0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      rec_start = v.rs; play_start = v.ps; stop = v.sp;
      adc_valid = v.av; adc_sample = v.smp;
      tick();
      rec_start = 0; play_start = 0; stop = 0; adc_valid = 0;
      chk("vec_cs", mem_chipselect, v.cs);
      chk("vec_we", mem_write, v.cs);
      chk("vec_be", mem_byteenable, v.cs ? 2'b11 : 2'b00);
      if (v.cs) begin
        chk("vec_addr", mem_address, v.addr);
        chk("vec_wd", mem_writedata, v.smp);
      end
      chk("vec_busy", busy, v.bz);
      chk("vec_cnt", rec_count, v.cnt);
      chk("vec_full", full, v.fl);
      $display("vec %0d rs=%0b ps=%0b sp=%0b av=%0b smp=%h cs=%0b addr=%0d cnt=%0d",
               i, v.rs, v.ps, v.sp, v.av, v.smp, mem_chipselect, mem_address, rec_count);
    end

    play_exp[0] = 16'h1111; play_exp[1] = 16'h2222;
    play_exp[2] = 16'h3333; play_exp[3] = 16'h4444;
    play_seq(4, -1, 0);
    chk("play_cnt_hold", rec_count, 4);
    play_seq(4, 1, 10);

    // Stop together with adc_valid: the sample is still written and counted.
    rec_start = 1'b1;
    tick();
    rec_start = 1'b0;
    adc_valid = 1'b1; adc_sample = 16'hAAAA; stop = 1'b1;
    tick();
    adc_valid = 1'b0; stop = 1'b0;
    chk("stopwr_cs", mem_chipselect, 1);
    chk("stopwr_we", mem_write, 1);
    chk("stopwr_addr", mem_address, 0);
    chk("stopwr_wd", mem_writedata, 16'hAAAA);
    chk("stopwr_busy", busy, 0);
    chk("stopwr_cnt", rec_count, 1);
    $display("stop+write addr=0 data=aaaa cnt=%0d", rec_count);

    // Stop in PLAY_WAIT discards the read data.
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    chk("pstop_rd_cs", mem_chipselect, 1);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("pstop_busy", busy, 0);
    chk("pstop_dv", dac_valid, 0);
    tick();
    chk("pstop_dv2", dac_valid, 0);
    chk("pstop_cs", mem_chipselect, 0);
    $display("play stop in wait busy=%0b", busy);

    // Fill the 8-word memory with 10 back-to-back samples.
    rec_start = 1'b1;
    tick();
    rec_start = 1'b0;
    chk("fill_clr_cnt", rec_count, 0);
    for (int k = 0; k < 10; k++) begin
      adc_valid = 1'b1; adc_sample = 16'h5000 + 16'(k);
      tick();
      chk("fill_cs", mem_chipselect, k < 8);
      if (k < 8) begin
        chk("fill_addr", mem_address, k);
        chk("fill_wd", mem_writedata, 16'h5000 + 16'(k));
      end
      chk("fill_cnt", rec_count, (k < 8) ? k + 1 : 8);
      chk("fill_full", full, k >= 7);
      chk("fill_busy", busy, k < 7);
      $display("fill pulse %0d cs=%0b cnt=%0d full=%0b", k + 1, mem_chipselect, rec_count, full);
    end
    adc_valid = 1'b0;

    // Reset asserted just after the 5th write of a recording.
    rec_start = 1'b1;
    tick();
    rec_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      adc_valid = 1'b1; adc_sample = 16'h6000 + 16'(k);
      tick();
      chk("rrst_cs", mem_chipselect, 1);
      chk("rrst_addr", mem_address, k);
    end
    reset_reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick(); tick();
    reset_reset_n = 1'b1;
    tick();
    chk("postrst_cs", mem_chipselect, 0);
    chk("postrst_busy", busy, 0);
    chk("postrst_clken", mem_clken, 1);
    chk("postrst_cnt", rec_count, 0);
    tick();
    chk("postrst_cs2", mem_chipselect, 0);
    adc_valid = 1'b0;
    $display("reset mid-record done cnt=%0d", rec_count);

    // play_start with nothing recorded is ignored.
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    chk("zplay_busy", busy, 0);
    chk("zplay_cs", mem_chipselect, 0);
    tick();
    chk("zplay_cs2", mem_chipselect, 0);
    $display("play with zero count busy=%0b", busy);

    // Two-sample recording, then playback (wrapping when looping is built in).
    rec_start = 1'b1;
    tick();
    rec_start = 1'b0;
    adc_valid = 1'b1; adc_sample = 16'h0A0A;
    tick();
    adc_sample = 16'h0B0B;
    tick();
    adc_valid = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("rec2_cnt", rec_count, 2);
    chk("rec2_busy", busy, 0);
    play_exp[0] = 16'h0A0A; play_exp[1] = 16'h0B0B;
`ifdef AUDIO_MEM_LOOP_PLAYBACK_EN
    play_start = 1'b1;
    dac_ready  = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      play_start = 1'b0;
      chk("loop_cs", mem_chipselect, 1);
      chk("loop_addr", mem_address, j % 2);
      tick();
      tick();
      chk("loop_dv", dac_valid, 1);
      chk("loop_smp", dac_sample, play_exp[j % 2]);
      $display("loop read %0d addr=%0d data=%h", j, j % 2, dac_sample);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    dac_ready = 1'b0;
    chk("loop_stop_busy", busy, 0);
    chk("loop_stop_dv", dac_valid, 0);
`else
    play_seq(2, -1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_mem_streamer.md
Name: audio_mem_streamer

Overview:
- Avalon-MM master that drives the on-chip sample memory's s1 slave port: 18-bit word address, 16-bit data, byteenable, clken, chipselect, write.
- Record mode writes ADC samples from the WM8731 receive path into memory.
- Playback mode reads the stored samples back and hands them to the DAC transmit path with a valid/ready handshake.
- Sits between the codec serial-interface logic and the Qsys system's memory port.

Parameters:
- ADDR_W, 18, memory word-address width.
- DATA_W, 16, sample/word width.
- DEPTH, 262144, number of memory words; must be ≤ 2^ADDR_W.

Ports:
- clk_clk  in  1  system clock, same clock as the memory slave.
- reset_reset_n  in  1  asynchronous active-low reset.
- rec_start  in  1  one-cycle pulse: begin recording at address 0.
- play_start  in  1  one-cycle pulse: begin playback at address 0.
- stop  in  1  one-cycle pulse: abort the current operation.
- adc_sample  in  DATA_W  sample from the receive path.
- adc_valid  in  1  adc_sample is valid this cycle.
- dac_sample  out  DATA_W  sample to the transmit path.
- dac_valid  out  1  dac_sample is valid.
- dac_ready  in  1  transmit path accepts dac_sample.
- mem_address  out  ADDR_W  s1 address.
- mem_chipselect  out  1  s1 chipselect.
- mem_write  out  1  s1 write.
- mem_clken  out  1  s1 clock enable.
- mem_byteenable  out  DATA_W/8  s1 byteenable.
- mem_writedata  out  DATA_W  s1 writedata.
- mem_readdata  in  DATA_W  s1 readdata; read latency 1.
- busy  out  1  state is not IDLE.
- rec_count  out  ADDR_W+1  number of samples recorded by the last recording.
- full  out  1  sticky flag: last recording ended because memory filled.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0, including rec_count, full, dac_sample and mem_clken.
- From the first clock after reset, mem_clken is 1.
- All outputs are registered.
- mem_byteenable is all-ones whenever mem_chipselect is 1, and 0 otherwise.
- States: IDLE, REC, PLAY_RD, PLAY_WAIT, PLAY_HOLD.
- IDLE:
  - rec_start: go to REC; address pointer = 0, rec_count = 0, full = 0.
  - play_start with rec_count ≠ 0: go to PLAY_RD; pointer = 0.
  - play_start with rec_count = 0: ignored.
  - rec_start and play_start in the same cycle: rec_start wins.
  - stop: no effect.
- REC:
  - adc_valid in cycle N → in cycle N+1 exactly one write: mem_chipselect = 1, mem_write = 1, mem_address = pointer, mem_writedata = adc_sample.
  - After that write, pointer and rec_count each increment by 1.
  - Back-to-back adc_valid gives back-to-back writes.
  - When rec_count reaches DEPTH: set full, return to IDLE; further adc_valid is ignored.
  - stop: return to IDLE. If adc_valid coincides with stop, that sample is still written and counted.
  - rec_start or play_start while in REC: ignored.
- PLAY_RD: one cycle with mem_chipselect = 1, mem_write = 0, mem_address = pointer. Next state PLAY_WAIT.
- PLAY_WAIT: capture mem_readdata into dac_sample; set dac_valid = 1 from the next cycle. Next state PLAY_HOLD.
- PLAY_HOLD:
  - Hold dac_sample and dac_valid until dac_valid & dac_ready.
  - On that handshake: dac_valid drops the next cycle and pointer increments.
  - If pointer was rec_count − 1: go to IDLE. Otherwise go to PLAY_RD.
  - Minimum samples period: 3 cycles.
- stop in any PLAY state: go to IDLE; dac_valid is 0 the next cycle; any in-flight read data is discarded.
- busy = (state ≠ IDLE).
- rec_count and full hold their values in IDLE and during playback.

Optional Feature:
- Macro: AUDIO_MEM_LOOP_PLAYBACK_EN
- Defined: after the handshake of the last sample (pointer = rec_count − 1), pointer wraps to 0 and playback continues at PLAY_RD. Only stop ends playback.
- Undefined: playback ends in IDLE after the last sample.

Test Plan:
- Reset mid-REC at the 5th write → all outputs 0 immediately; rec_count = 0; state IDLE; no further writes after reset is released.
- rec_start, then 4 adc_valid pulses with samples 0x1111..0x4444, then stop → writes to addresses 0..3 with matching data, each one cycle after its adc_valid; rec_count = 4; full = 0.
- play_start after that recording with dac_ready held 1 → reads addresses 0..3; dac_sample sequence 0x1111..0x4444; first dac_valid 3 cycles after play_start; busy = 0 after the 4th handshake.
- Playback with dac_ready low for 10 cycles at the 2nd sample → dac_sample 0x2222 held stable with dac_valid = 1; no new memory read until the handshake.
- DEPTH = 8 build, 10 adc_valid pulses → 8 writes; full = 1; rec_count = 8; adc_valid pulses 9–10 produce no write.
- play_start with rec_count = 0 → busy stays 0; no chipselect. With the macro defined and rec_count = 2 → address sequence 0, 1, 0, 1 … until stop.
